mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every non-clock signal of the two-requester memory arbiter.
//   Port 0 is instruction fetch and is read-only. Port 1 is data load/store.
//   The mem* group is the single shared mmu port (vaddr/data/byteena/memWE/q).
//
//   Modports:
//     slave  - arbiter view: takes requests and memQ; drives ready, response and mmu bus
//     master - environment view: requesters plus the mmu model
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req0Valid;
  logic [ADDR_W-1:0] req0Addr;
  logic              req0Ready;
  logic              resp0Valid;
  logic [31:0]       resp0Data;

  logic              req1Valid;
  logic [ADDR_W-1:0] req1Addr;
  logic [31:0]       req1Data;
  logic [3:0]        req1Byteena;
  logic              req1WE;
  logic              req1Ready;
  logic              resp1Valid;
  logic [31:0]       resp1Data;

  logic [ADDR_W-1:0] memVaddr;
  logic [31:0]       memData;
  logic [3:0]        memByteena;
  logic              memWE;
  logic [31:0]       memQ;

  modport slave (
    input  req0Valid, req0Addr,
    input  req1Valid, req1Addr, req1Data, req1Byteena, req1WE,
    input  memQ,
    output req0Ready, resp0Valid, resp0Data,
    output req1Ready, resp1Valid, resp1Data,
    output memVaddr, memData, memByteena, memWE
  );

  modport master (
    output req0Valid, req0Addr,
    output req1Valid, req1Addr, req1Data, req1Byteena, req1WE,
    output memQ,
    input  req0Ready, resp0Valid, resp0Data,
    input  req1Ready, resp1Valid, resp1Data,
    input  memVaddr, memData, memByteena, memWE
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single mmu memory/UART port between instruction fetch (port 0)
//   and data load/store (port 1). Arbitration is round-robin, and only one
//   transaction is outstanding at a time. For each transaction the FSM moves
//   IDLE -> BUSY (LAT cycles, mmu bus held stable) -> RESP (1-cycle response
//   pulse) -> IDLE.
//
//   Parameters:
//     LAT     cycles from the first BUSY cycle to a valid memQ (1..15)
//     ADDR_W  address width for both requesters and the mmu port
//
//   Ports:
//     clock  system clock; all state changes happen on its rising edge
//     RST    asynchronous, active-high reset
//     bus    mem_arbiter_if.slave, carrying:
//              requests:  req0*/req1*
//              responses: resp0*/resp1*
//              mmu bus:   memVaddr/memData/memByteena/memWE/memQ
module mem_arbiter #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 32
) (
  input  logic          clock,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  // cnt is only 4 bits wide, so a latency outside 1..15 cannot be counted.
  if ((LAT < 1) || (LAT > 15)) begin : gLatRangeCheck
    $error("mem_arbiter: LAT must be within 1..15");
  end

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              prio;      // port that wins when both requesters are valid
  logic              curPort;   // port that owns the transaction in flight
  logic [ADDR_W-1:0] vaddrR;
  logic [31:0]       dataR;
  logic [3:0]        byteenaR;
  logic              weR;       // latched write flag; decides the response data
  logic              memWeR;    // high for the first BUSY cycle of a write only
  logic              resp0ValidR, resp1ValidR;
  logic [31:0]       resp0DataR, resp1DataR;

  // A lone valid requester wins regardless of prio, so no idle bubble is inserted.
  // The two grant terms are mutually exclusive by construction.
  logic grant0, grant1, canGrant;
  assign grant0   = bus.req0Valid && (!bus.req1Valid || !prio);
  assign grant1   = bus.req1Valid && (!bus.req0Valid ||  prio);
  // Gating with RST keeps ready low throughout reset, however the release is timed.
  assign canGrant = (state == IDLE) && !RST;

  assign bus.req0Ready  = canGrant && grant0;
  assign bus.req1Ready  = canGrant && grant1;
  assign bus.resp0Valid = resp0ValidR;
  assign bus.resp0Data  = resp0DataR;
  assign bus.resp1Valid = resp1ValidR;
  assign bus.resp1Data  = resp1DataR;
  assign bus.memVaddr   = vaddrR;
  assign bus.memData    = dataR;
  assign bus.memByteena = byteenaR;
  assign bus.memWE      = memWeR;

  // NOTE: every register below uses non-blocking assignment, so all of them
  // update together at the clock edge, whatever order they appear in.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      prio        <= 1'b0;
      curPort     <= 1'b0;
      vaddrR      <= '0;
      dataR       <= 32'd0;
      byteenaR    <= 4'd0;
      weR         <= 1'b0;
      memWeR      <= 1'b0;
      resp0ValidR <= 1'b0;
      resp1ValidR <= 1'b0;
      resp0DataR  <= 32'd0;
      resp1DataR  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            curPort <= grant1;
            prio    <= grant0;        // the loser gets priority next time
            cnt     <= 4'd0;
            state   <= BUSY;
            if (grant1) begin
              vaddrR   <= bus.req1Addr;
              dataR    <= bus.req1Data;
              byteenaR <= bus.req1Byteena;
              weR      <= bus.req1WE;
              memWeR   <= bus.req1WE;
            end else begin
              // Instruction fetch is always a full-word read.
              vaddrR   <= bus.req0Addr;
              dataR    <= 32'd0;
              byteenaR <= 4'hF;
              weR      <= 1'b0;
              memWeR   <= 1'b0;
            end
          end
        end

        BUSY: begin
          memWeR <= 1'b0;             // gives exactly one write pulse per access
          cnt    <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= RESP;
            if (curPort) begin
              resp1DataR  <= weR ? 32'd0 : bus.memQ;
              resp1ValidR <= 1'b1;
            end else begin
              resp0DataR  <= bus.memQ;
              resp0ValidR <= 1'b1;
            end
          end
        end

        RESP: begin
          resp0ValidR <= 1'b0;
          resp1ValidR <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with LAT=2.
//   A table of single transactions is applied in a loop. Hand-written
//   sequences then cover round-robin alternation, starvation freedom, and
//   reset asserted in the middle of a write.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clock = 1'b0;
  logic RST;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.LAT(LAT), .ADDR_W(32)) dut (
    .clock (clock),
    .RST   (RST),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] lastResp [2];   // expected held respNData per port

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] q;
    logic [31:0] expData;
    logic [3:0]  expBe;
    logic        expWe;
    logic [31:0] expResp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus.req0Valid   = 1'b0;
    bus.req0Addr    = 32'd0;
    bus.req1Valid   = 1'b0;
    bus.req1Addr    = 32'd0;
    bus.req1Data    = 32'd0;
    bus.req1Byteena = 4'd0;
    bus.req1WE      = 1'b0;
    bus.memQ        = 32'd0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    idleInputs();
    lastResp[0] = 32'd0;
    lastResp[1] = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    RST = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Returns the granted port, or -1 after the cycle budget runs out.
  task automatic waitGrant(input string name, output int p);
    p = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.req0Ready || bus.req1Ready) begin
        check({name, " ready one-hot"}, 32'(bus.req0Ready & bus.req1Ready), 32'd0);
        p = bus.req1Ready ? 1 : 0;
        break;
      end
    end
    if (p < 0) check({name, " grant timeout"}, 32'd0, 32'd1);
  endtask

  // Checks the LAT BUSY cycles. memQ carries junk except in the last BUSY
  // cycle, so a response sampled on the wrong edge is caught.
  task automatic checkBusy(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic we, input logic [31:0] q);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      check({name, " memVaddr"}, bus.memVaddr, addr);
      check({name, " memData"}, bus.memData, data);
      check({name, " memByteena"}, 32'(bus.memByteena), 32'(be));
      check({name, " memWE"}, 32'(bus.memWE), (k == 1) ? 32'(we) : 32'd0);
      check({name, " busy ready"}, 32'({bus.req0Ready, bus.req1Ready}), 32'd0);
      check({name, " busy respValid"}, 32'({bus.resp0Valid, bus.resp1Valid}), 32'd0);
      bus.memQ = (k == LAT) ? q : (32'hBAD0_0000 | 32'(k));
    end
  endtask

  task automatic checkResp(input string name, input int p, input logic [31:0] expD);
    @(negedge clock);
    check({name, " resp0Valid"}, 32'(bus.resp0Valid), (p == 0) ? 32'd1 : 32'd0);
    check({name, " resp1Valid"}, 32'(bus.resp1Valid), (p == 1) ? 32'd1 : 32'd0);
    check({name, " resp memWE"}, 32'(bus.memWE), 32'd0);
    lastResp[p] = expD;
    check({name, " resp0Data"}, bus.resp0Data, lastResp[0]);
    check({name, " resp1Data"}, bus.resp1Data, lastResp[1]);
  endtask

  task automatic runVec(input vec_t v, input string name);
    int p;
    @(posedge clock);
    #1;
    // Port 1 fields are driven even for port 0 vectors; they must be ignored.
    bus.req1Addr    = v.addr;
    bus.req1Data    = v.wdata;
    bus.req1Byteena = v.be;
    bus.req1WE      = v.we;
    if (v.port == 0) begin
      bus.req0Addr  = v.addr;
      bus.req0Valid = 1'b1;
    end else begin
      bus.req1Valid = 1'b1;
    end
    waitGrant(name, p);
    check({name, " granted port"}, 32'(p), 32'(v.port));
    @(posedge clock);
    #1;
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    checkBusy(name, v.addr, v.expData, v.expBe, v.expWe, v.q);
    checkResp(name, v.port, v.expResp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int n1;
    logic [31:0] a;
    int expOrder [4];

    //            port we    addr         wdata         be     q             expData       expBe  expWe expResp
    vecs[0] = '{0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h3, 32'hDEAD_BEEF, 32'h0000_0000, 4'hF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 32'hCAFE_F00D, 32'h1234_5678, 4'h3, 1'b1, 32'h0000_0000};
    vecs[2] = '{1, 1'b0, 32'h0000_0104, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0000_0000, 4'hF, 1'b0, 32'h0BAD_F00D};
    vecs[3] = '{1, 1'b1, 32'h0000_0201, 32'h0000_0041, 4'h1, 32'h7777_7777, 32'h0000_0041, 4'h1, 1'b1, 32'h0000_0000};
    vecs[4] = '{0, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 32'h1122_3344, 32'h0000_0000, 4'hF, 1'b0, 32'h1122_3344};

    // Reset state: nothing is granted while RST is high, even with both requesters valid.
    RST = 1'b1;
    idleInputs();
    lastResp[0] = 32'd0;
    lastResp[1] = 32'd0;
    bus.req0Valid = 1'b1;
    bus.req1Valid = 1'b1;
    repeat (2) @(negedge clock);
    check("reset ready", 32'({bus.req0Ready, bus.req1Ready}), 32'd0);
    check("reset memWE", 32'(bus.memWE), 32'd0);
    check("reset respValid", 32'({bus.resp0Valid, bus.resp1Valid}), 32'd0);
    check("reset memVaddr", bus.memVaddr, 32'd0);
    check("reset resp1Data", bus.resp1Data, 32'd0);
    RST = 1'b0;
    #1;
    check("release req0Ready", 32'(bus.req0Ready), 32'd1);
    check("release req1Ready", 32'(bus.req1Ready), 32'd0);
    bus.req0Valid = 1'b0;   // withdraw before the edge: no grant
    bus.req1Valid = 1'b0;
    @(negedge clock);
    check("withdraw memVaddr", bus.memVaddr, 32'd0);

    // Single-transaction table; the last entry is a port 0 grant, which leaves prio = 1.
    for (int i = 0; i < 5; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // Round-robin: both valid continuously after reset gives grants 0,1,0,1,0,1.
    doReset();
    bus.req0Addr    = 32'h0000_1000;
    bus.req1Addr    = 32'h0000_2000;
    bus.req1Byteena = 4'hF;
    bus.req0Valid   = 1'b1;
    bus.req1Valid   = 1'b1;
    for (int g = 0; g < 6; g++) begin
      waitGrant($sformatf("rr%0d", g), p);
      check($sformatf("rr%0d port", g), 32'(p), 32'(g % 2));
      if (p < 0) break;
      @(posedge clock);
      #1;
      checkBusy($sformatf("rr%0d", g), (p == 1) ? 32'h0000_2000 : 32'h0000_1000, 32'd0, 4'hF,
                1'b0, 32'h5000_0000 + 32'(g));
      checkResp($sformatf("rr%0d", g), p, 32'h5000_0000 + 32'(g));
    end

    // Starvation freedom: req1 issues 3 reads back to back, and req0 is raised after the first.
    doReset();
    expOrder = '{1, 0, 1, 1};
    n1 = 0;
    bus.req1Addr    = 32'h0000_0300;
    bus.req1Byteena = 4'hF;
    bus.req1Valid   = 1'b1;
    bus.req0Addr    = 32'h0000_0400;
    for (int g = 0; g < 4; g++) begin
      waitGrant($sformatf("starve%0d", g), p);
      check($sformatf("starve%0d port", g), 32'(p), 32'(expOrder[g]));
      if (p < 0) break;
      a = (p == 1) ? bus.req1Addr : bus.req0Addr;
      @(posedge clock);
      #1;
      if (p == 1) begin
        n1++;
        bus.req1Addr = bus.req1Addr + 32'd4;
        if (n1 == 3) bus.req1Valid = 1'b0;
      end else begin
        bus.req0Valid = 1'b0;
      end
      if (g == 0) bus.req0Valid = 1'b1;
      checkBusy($sformatf("starve%0d", g), a, 32'd0, 4'hF, 1'b0, 32'h6000_0000 + 32'(g));
      checkResp($sformatf("starve%0d", g), p, 32'h6000_0000 + 32'(g));
    end

    // Reset during the write pulse drops the access and leaves no response behind.
    @(posedge clock);
    #1;
    bus.req1Addr    = 32'h0000_0500;
    bus.req1Data    = 32'h0000_00AA;
    bus.req1Byteena = 4'hF;
    bus.req1WE      = 1'b1;
    bus.req1Valid   = 1'b1;
    waitGrant("rstmid", p);
    check("rstmid port", 32'(p), 32'd1);
    @(posedge clock);
    #1;
    check("rstmid memWE before", 32'(bus.memWE), 32'd1);
    bus.req0Valid = 1'b1;
    bus.req0Addr  = 32'h0000_0600;
    #1;
    RST = 1'b1;
    #1;
    check("rstmid memWE", 32'(bus.memWE), 32'd0);
    check("rstmid ready", 32'({bus.req0Ready, bus.req1Ready}), 32'd0);
    check("rstmid memVaddr", bus.memVaddr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rstmid held respValid", 32'({bus.resp0Valid, bus.resp1Valid}), 32'd0);
      check("rstmid held ready", 32'({bus.req0Ready, bus.req1Ready}), 32'd0);
    end
    RST = 1'b0;
    #1;
    check("rstmid prio req0Ready", 32'(bus.req0Ready), 32'd1);
    check("rstmid prio req1Ready", 32'(bus.req1Ready), 32'd0);
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clock);
      check("rstmid no resp", 32'({bus.resp0Valid, bus.resp1Valid}), 32'd0);
      check("rstmid no memWE", 32'(bus.memWE), 32'd0);
    end
    check("rstmid resp1Data", bus.resp1Data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
